snes_pad_reader: RTL and testbench
==================================

Name: snes_pad_reader

Overview:
- Initiator side of the (S)NES serial pad protocol: drives latch/clock to a physical SNES pad, shifts in its 16 serial bits and presents a 12-bit active-low button word in the same bit order as the adapter's shift-out button bus.
- The word feeds the existing SNES, Genesis and 3DO encoders directly.
- Polling is free-running at a fixed frame rate, with a one-cycle pulse per completed frame.

Parameters:
- LATCH_CYCLES, 600, latch high time in system_clock cycles (12 us @ 50 MHz).
- HALF_CYCLES, 300, each pad_clk low/high phase in cycles (6 us @ 50 MHz); must be >= 4.
- POLL_CYCLES, 833333, frame start period in cycles (60 Hz @ 50 MHz); must be > LATCH_CYCLES + 33*HALF_CYCLES + 1.

Ports:
- system_clock  in  1  sole clock.
- system_reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = start frames at each poll tick; 0 = stay idle after the current frame.
- pad_latch  out  1  to pad latch pin, active-high.
- pad_clk  out  1  to pad clock pin, idle high.
- pad_data  in  1  from pad; asynchronous; board pull-down.
- buttons  out  12  active-low: [0]B [1]Y [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right [8]A [9]X [10]L [11]R.
- pad_present  out  1  last frame carried a valid pad ID.
- frame_valid  out  1  one-cycle pulse when buttons/pad_present update.

Behaviour:
- Clocking and reset:
  - Single clock domain, synchronous active-high reset on system_clock; all outputs registered.
  - Reset values: pad_latch=0, pad_clk=1, buttons=12'hFFF, pad_present=0, frame_valid=0, state=IDLE, poll counter=0, bit index=0.
- Input sync: pad_data passes through a 2-flop synchronizer; all samples use the synced value (2-cycle latency).
- Poll counter: counts 0..POLL_CYCLES-1 and wraps, free-running. A frame starts when the counter is 0, state is IDLE and enable=1. The first frame therefore starts on the first cycle after reset deasserts (if enable=1).
- FSM states and timing; phase counter reloads on every state entry:
  - IDLE: latch=0, clk=1. Leaves to LATCH on a poll tick with enable=1.
  - LATCH: latch=1, clk=1 for LATCH_CYCLES cycles, then GAP.
  - GAP: latch=0, clk=1 for HALF_CYCLES cycles, then CLK_LOW.
  - CLK_LOW: clk=0 for HALF_CYCLES. On its last cycle, raw[bit_idx] <= synced pad_data. The sample lands before the rising edge; the pad shifts on the rising edge.
  - CLK_HIGH: clk=1 for HALF_CYCLES. Then if bit_idx==15 go to DONE; else bit_idx+1 and go to CLK_LOW.
  - DONE: one cycle, then IDLE.
    - present = (raw[15:12]==4'hF).
    - buttons <= present ? raw[11:0] : 12'hFFF.
    - pad_present <= present.
    - frame_valid=1 on the following cycle (registered), for exactly one cycle.
- Frame shape: exactly 16 clock pulses per frame. Frame length = LATCH_CYCLES + HALF_CYCLES + 32*HALF_CYCLES + 1 cycles.
- Output stability: buttons and pad_present change only on frame_valid; they hold between frames. No partial-frame update ever.
- enable dropped mid-frame: the frame completes normally; no new frame starts while enable=0. Re-assert takes effect at the next poll counter wrap.
- Reset mid-frame: abort; all outputs return to reset values on the next edge; no frame_valid.
- Absent pad (all-zero read): pad_present=0, buttons=12'hFFF (all released), frame_valid still pulses.

Decomposition:
- Package snes_pad_pkg:
  - FSM state enum.
  - Default timing constants.
  - Button index constants BTN_B..BTN_R (0..11).
  - PAD_ID_BITS=4'hF.
  - Shared by the encoders and their benches.
- One sub-module: sync_2ff (2-flop synchronizer, 1-bit, reset to 0).

Test Plan:
- Bench parameters: LATCH_CYCLES=6, HALF_CYCLES=4, POLL_CYCLES=200, throughout.
- Bench model: pad shifting on rising edges, word 16'hF000 | buttons-pressed-low; reset released with enable=1.
  - Response: latch high exactly 6 cycles from cycle 1, then 16 clk low pulses of 4 cycles each.
  - Response: frame_valid at cycle 1+6+4+128+1+1.
- Pad word B and Start pressed (raw 16'hFFF6):
  - buttons=12'hFF6, pad_present=1.
  - buttons stable until the next frame_valid.
- pad_data tied 0 (no pad): pad_present=0, buttons=12'hFFF, frame_valid still pulses once per 200 cycles.
- enable deasserted during CLK_LOW of bit 7: the current frame finishes with 16 pulses; no latch while enable=0; after re-assert, the next latch starts when the counter wraps to 0.
- Reset asserted for 1 cycle during LATCH:
  - Next edge: pad_latch=0, pad_clk=1, buttons=12'hFFF, pad_present=0, no frame_valid.
  - New frame starts the cycle after reset deasserts.
- Pad changes buttons between two frames (12'hFFE then 12'h7FF): two frame_valid pulses with buttons 12'hFFE then 12'h7FF, and no intermediate values.

Source files
------------

// File: rtl/snes_pad_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_pkg
// Description : Shared definitions for the SNES pad reader and the encoders
//               that consume its button word: FSM states, default timing,
//               button bit positions and the pad ID nibble.
// Revision    : 1.0 - initial release
// ============================================================================
package snes_pad_pkg;

    // Reader FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LATCH    = 3'd1,
        ST_GAP      = 3'd2,
        ST_CLK_LOW  = 3'd3,
        ST_CLK_HIGH = 3'd4,
        ST_DONE     = 3'd5
    } pad_state_e;

    // Default timing for a 50 MHz system clock
    localparam int DEF_LATCH_CYCLES = 600;     // 12 us latch pulse
    localparam int DEF_HALF_CYCLES  = 300;     // 6 us per pad_clk phase
    localparam int DEF_POLL_CYCLES  = 833333;  // 60 Hz frame rate

    // Frame geometry
    localparam int NUM_BUTTONS = 12;
    localparam int NUM_BITS    = 16;

    // Button bit positions in the active-low button word
    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // A genuine pad reads its four trailing bits as all ones
    localparam logic [3:0]             PAD_ID_BITS      = 4'hF;
    localparam logic [NUM_BUTTONS-1:0] BUTTONS_RELEASED = 12'hFFF;

    // True when a raw 16-bit read carries a valid pad ID
    function automatic logic pad_id_ok(input logic [NUM_BITS-1:0] raw);
        return raw[15:12] == PAD_ID_BITS;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snes_pad_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_reader_if
// Description : Pad-side pins plus the button-word output bus of the reader.
//               master = reader, slave = pad / consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface snes_pad_reader_if;
    import snes_pad_pkg::*;

    logic                   enable;
    logic                   pad_latch;
    logic                   pad_clk;
    logic                   pad_data;
    logic [NUM_BUTTONS-1:0] buttons;
    logic                   pad_present;
    logic                   frame_valid;

    modport master (
        input  enable,
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output buttons,
        output pad_present,
        output frame_valid
    );

    modport slave (
        output enable,
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  buttons,
        input  pad_present,
        input  frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/snes_pad_reader_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous bit, reset 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops give metastability time to resolve
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/snes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : snes_pad_reader
// Description : Free-running SNES pad poller. Drives latch/clock, shifts in
//               16 serial bits and publishes a 12-bit active-low button word
//               with a one-cycle frame_valid pulse per completed frame.
// Revision    : 1.0 - initial release
// ============================================================================
module snes_pad_reader
    import snes_pad_pkg::*;
#(
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
    parameter int POLL_CYCLES  = DEF_POLL_CYCLES
) (
    input  wire logic          system_clock,
    input  wire logic          system_reset,
    snes_pad_reader_if.master  pad
);

    // State encoding
    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_LATCH    = ST_LATCH;
    localparam logic [2:0] S_GAP      = ST_GAP;
    localparam logic [2:0] S_CLK_LOW  = ST_CLK_LOW;
    localparam logic [2:0] S_CLK_HIGH = ST_CLK_HIGH;
    localparam logic [2:0] S_DONE     = ST_DONE;

    // Counter widths and reload values
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHASE_W   = $clog2(PHASE_MAX);
    localparam int POLL_W    = $clog2(POLL_CYCLES);

    localparam logic [PHASE_W-1:0] LATCH_LOAD = PHASE_W'(LATCH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] HALF_LOAD  = PHASE_W'(HALF_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
    localparam logic [POLL_W-1:0]  POLL_ONE   = POLL_W'(1);
    localparam logic [3:0]         LAST_BIT   = 4'(NUM_BITS - 1);

    logic [2:0]             r_state;
    logic [PHASE_W-1:0]     r_phase;
    logic [3:0]             r_bit_idx;
    logic [NUM_BITS-1:0]    r_raw;
    logic [POLL_W-1:0]      r_poll;
    logic                   r_latch;
    logic                   r_clk;
    logic                   r_commit;
    logic [NUM_BUTTONS-1:0] r_buttons;
    logic                   r_present;
    logic                   r_valid;

    logic w_data_sync;
    logic w_poll_tick;
    logic w_phase_end;
    logic w_raw_present;

    sync_2ff u_sync (
        .clk (system_clock),
        .rst (system_reset),
        .d   (pad.pad_data),
        .q   (w_data_sync)
    );

    assign w_poll_tick   = (r_poll == '0) && pad.enable;
    assign w_phase_end   = (r_phase == '0);
    assign w_raw_present = pad_id_ok(r_raw);

    // Free-running frame-rate counter, independent of enable
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_poll <= '0;
        end else if (r_poll == POLL_LAST) begin
            r_poll <= '0;
        end else begin
            r_poll <= r_poll + POLL_ONE;
        end
    end

    // Frame sequencer: latch, gap, 16 clock pulses, then hand off to commit
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_bit_idx <= '0;
            r_raw     <= '0;
            r_latch   <= 1'b0;
            r_clk     <= 1'b1;
            r_commit  <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_poll_tick) begin
                        r_state   <= S_LATCH;
                        r_phase   <= LATCH_LOAD;
                        r_bit_idx <= '0;
                        r_latch   <= 1'b1;
                        r_clk     <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (w_phase_end) begin
                        r_state <= S_GAP;
                        r_phase <= HALF_LOAD;
                        r_latch <= 1'b0;
                    end else begin
                        r_phase <= r_phase - PHASE_ONE;
                    end
                end
                S_GAP: begin
                    if (w_phase_end) begin
                        r_state <= S_CLK_LOW;
                        r_phase <= HALF_LOAD;
                        r_clk   <= 1'b0;
                    end else begin
                        r_phase <= r_phase - PHASE_ONE;
                    end
                end
                S_CLK_LOW: begin
                    // Sample at the end of the low phase, before the pad shifts
                    if (w_phase_end) begin
                        r_raw[r_bit_idx] <= w_data_sync;
                        r_state          <= S_CLK_HIGH;
                        r_phase          <= HALF_LOAD;
                        r_clk            <= 1'b1;
                    end else begin
                        r_phase <= r_phase - PHASE_ONE;
                    end
                end
                S_CLK_HIGH: begin
                    if (w_phase_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_state   <= S_CLK_LOW;
                            r_phase   <= HALF_LOAD;
                            r_clk     <= 1'b0;
                        end
                    end else begin
                        r_phase <= r_phase - PHASE_ONE;
                    end
                end
                S_DONE: begin
                    r_state  <= S_IDLE;
                    r_commit <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_latch <= 1'b0;
                    r_clk   <= 1'b1;
                end
            endcase
        end
    end

    // Publish the whole frame at once so consumers never see a partial word;
    // raw is untouched until the next frame's first sample, so it is still valid here
    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_buttons <= BUTTONS_RELEASED;
            r_present <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= r_commit;
            if (r_commit) begin
                r_buttons <= w_raw_present ? r_raw[NUM_BUTTONS-1:0] : BUTTONS_RELEASED;
                r_present <= w_raw_present;
            end
        end
    end

    assign pad.pad_latch   = r_latch;
    assign pad.pad_clk     = r_clk;
    assign pad.buttons     = r_buttons;
    assign pad.pad_present = r_present;
    assign pad.frame_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_snes_pad_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_snes_pad_reader
// Description : Self-checking bench for snes_pad_reader with a behavioural
//               shift-register pad and a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_pad_reader;

    localparam int LATCH = 6;
    localparam int HALF  = 4;
    localparam int POLL  = 200;
    // Frame landmarks, counted in cycles from the first latch-high cycle (1)
    localparam int CLK_FIRST = 1 + LATCH + HALF;          // first pad_clk low cycle
    localparam int CLK_LAST  = CLK_FIRST + 32 * HALF - 1; // last cycle of last high phase
    localparam int VALID_AT  = CLK_LAST + 3;              // after DONE and the commit cycle

    logic clk = 1'b0;
    logic rst = 1'b1;

    snes_pad_reader_if pif ();

    snes_pad_reader #(
        .LATCH_CYCLES (LATCH),
        .HALF_CYCLES  (HALF),
        .POLL_CYCLES  (POLL)
    ) dut (
        .system_clock (clk),
        .system_reset (rst),
        .pad          (pif)
    );

    always #5 clk = ~clk;

    // Pad model: parallel load while latched, shift one bit per rising pad_clk
    logic [15:0] pad_word = 16'h0000;
    logic [15:0] pad_sh   = 16'h0000;
    always @(posedge pif.pad_latch or posedge pif.pad_clk) begin
        if (pif.pad_latch) pad_sh <= pad_word;
        else               pad_sh <= {1'b0, pad_sh[15:1]};
    end
    assign pif.pad_data = pad_sh[0];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_btn  = 12'hFFF;
    logic        exp_pres = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One poll period starting just before the poll tick edge. active says
    // whether a frame is expected; enable may be toggled at given cycles.
    task automatic period(input logic [15:0] word, input bit active,
                          input int drop_at, input int raise_at);
        int          lat_err = 0;
        int          clk_err = 0;
        int          val_err = 0;
        int          bus_err = 0;
        logic        el, ec, ev;
        logic [11:0] nb, want_b;
        logic        np, want_p;
        np = (word[15:12] == 4'hF);
        nb = np ? word[11:0] : 12'hFFF;
        pad_word = word;
        for (int r = 1; r <= POLL; r++) begin
            @(negedge clk);
            el = active && (r <= LATCH);
            ec = !(active && r >= CLK_FIRST && r <= CLK_LAST && ((r - CLK_FIRST) % (2 * HALF)) < HALF);
            ev = active && (r == VALID_AT);
            want_b = (active && r >= VALID_AT) ? nb : exp_btn;
            want_p = (active && r >= VALID_AT) ? np : exp_pres;
            if (pif.pad_latch   !== el) lat_err++;
            if (pif.pad_clk     !== ec) clk_err++;
            if (pif.frame_valid !== ev) val_err++;
            if (pif.buttons !== want_b || pif.pad_present !== want_p) bus_err++;
            if (r == drop_at)  pif.enable = 1'b0;
            if (r == raise_at) pif.enable = 1'b1;
        end
        if (active) begin
            exp_btn  = nb;
            exp_pres = np;
        end
        chk("latch_shape", lat_err, 0);
        chk("clk_shape", clk_err, 0);
        chk("frame_valid_timing", val_err, 0);
        chk("bus_hold", bus_err, 0);
        chk("buttons", 32'(pif.buttons), 32'(exp_btn));
        chk("pad_present", 32'(pif.pad_present), 32'(exp_pres));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_latch"}, 32'(pif.pad_latch), 0);
        chk({tag, "_clk"}, 32'(pif.pad_clk), 1);
        chk({tag, "_buttons"}, 32'(pif.buttons), 32'hFFF);
        chk({tag, "_present"}, 32'(pif.pad_present), 0);
        chk({tag, "_valid"}, 32'(pif.frame_valid), 0);
    endtask

    initial begin
        logic [15:0] w;
        int          lat_hi;
        pif.enable = 1'b1;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");

        // B and Start pressed
        rst = 1'b0;
        period(16'hFFF6, 1'b1, 0, 0);

        // Random valid pads
        for (int i = 0; i < 3; i++) begin
            w = {4'hF, 12'($urandom)};
            period(w, 1'b1, 0, 0);
        end

        // No pad: data line stays low
        period(16'h0000, 1'b1, 0, 0);
        period(16'h0000, 1'b1, 0, 0);

        // Garbage ID nibble is treated as absent
        w = {4'($urandom_range(0, 14)), 12'($urandom)};
        period(w, 1'b1, 0, 0);

        // Button change between two frames
        period(16'hFFFE, 1'b1, 0, 0);
        period(16'hF7FF, 1'b1, 0, 0);

        // enable drops in CLK_LOW of bit 7; idle period; re-assert mid-period
        period(16'hF5A5, 1'b1, CLK_FIRST + 7 * 2 * HALF + 1, 0);
        period(16'hF0F0, 1'b0, 0, 50);
        period(16'hF0F0, 1'b1, 0, 0);

        // Reset for one cycle during LATCH
        pad_word = 16'hF3C3;
        lat_hi   = 0;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            if (pif.pad_latch === 1'b1) lat_hi++;
        end
        chk("latch_before_reset", lat_hi, 3);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_values("midframe_reset");
        exp_btn  = 12'hFFF;
        exp_pres = 1'b0;
        rst = 1'b0;
        period(16'hF3C3, 1'b1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
